// File: rtl/xor_sched_pkg.sv
// Shared types and width helpers for the XOR checksum scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, ID-width and length-width functions.
package xor_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a requester index. It is never zero, so a single requester
  // still gets a 1-bit field.
  function automatic int id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Width of a beat count. The extra bit lets the count reach MAX_LEN itself.
  function automatic int len_w(input int max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/xor_checksum_sched_rr_arbiter.sv
// Round-robin pick: the first set req bit at or after ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; the caller decides when the pick is consumed.
// Ports: req (N), ptr (IW) -> onehot (N), idx (IW), any (1).
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int c;
    c      = 0;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      c = (int'(ptr) + i) % N;
      if (!any && req[c]) begin
        any       = 1'b1;
        onehot[c] = 1'b1;
        idx       = IW'(c);
      end
    end
  end

endmodule

// File: rtl/xor_checksum_sched.sv
// Round-robin scheduler sharing one XOR checksum accumulator among NUM_REQ requesters.
// Latency: grant 1 cycle after req is sampled in IDLE; result valid the cycle after the final beat.
// Backpressure: in_ready only for the granted requester; the result is held until res_ready.
// Ports: clk, rst (async, active-high); req/in_valid/in_data/in_last/in_ready per requester;
//        grant (one-hot owner); res_valid/res_ready/res_data/res_id/res_len/res_err result port.
// Optional: define XOR_SCHED_TIMEOUT_EN to end a packet after TIMEOUT_CYC beat-free BUSY cycles.
module xor_checksum_sched
  import xor_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int MAX_LEN     = 16,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          in_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   in_data,
  input  logic [NUM_REQ-1:0]          in_last,
  output logic [NUM_REQ-1:0]          in_ready,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [DATA_W-1:0]           res_data,
  output logic [id_w(NUM_REQ)-1:0]    res_id,
  output logic [len_w(MAX_LEN)-1:0]   res_len,
  output logic                        res_err
);

  localparam int IW = id_w(NUM_REQ);
  localparam int LW = len_w(MAX_LEN);

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [LW-1:0]       cnt_q, cnt_d;
  logic                rv_q, rv_d;
  logic [DATA_W-1:0]   rdat_q, rdat_d;
  logic [IW-1:0]       rid_q, rid_d;
  logic [LW-1:0]       rlen_q, rlen_d;
  logic                rerr_q, rerr_d;

  logic [NUM_REQ-1:0]  arb_onehot;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;

  logic                sel_vld;
  logic                sel_last;
  logic [DATA_W-1:0]   sel_dat;
  logic                accept;
  logic                timeout;
  logic [LW-1:0]       cnt_inc;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (arb_onehot),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // Mux the owner's beat lanes; other requesters' lanes are never looked at.
  assign sel_vld  = in_valid[gidx_q];
  assign sel_last = in_last[gidx_q];
  assign sel_dat  = in_data[int'(gidx_q)*DATA_W +: DATA_W];
  assign accept   = (state_q == BUSY) && sel_vld;
  assign cnt_inc  = cnt_q + 1'b1;

  // grant_q is zero outside BUSY, but gating on state keeps in_ready
  // obviously tied to ownership.
  assign in_ready  = (state_q == BUSY) ? grant_q : '0;
  assign grant     = grant_q;
  assign res_valid = rv_q;
  assign res_data  = rdat_q;
  assign res_id    = rid_q;
  assign res_len   = rlen_q;
  assign res_err   = rerr_q;

`ifdef XOR_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdog_q;

  // Counts consecutive beat-free BUSY cycles; cleared on every accept and
  // whenever not BUSY, so each new grant starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
    end else if (state_q != BUSY || accept) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 1'b1;
    end
  end

  // Fires on the TIMEOUT_CYC-th idle cycle, so DONE is entered at that edge.
  assign timeout = (state_q == BUSY) && !accept && (wdog_q == WD_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rv_d    = rv_q;
    rdat_d  = rdat_q;
    rid_d   = rid_q;
    rlen_d  = rlen_q;
    rerr_d  = rerr_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d = BUSY;
          grant_d = arb_onehot;
          gidx_d  = arb_idx;
          acc_d   = '0;
          cnt_d   = '0;
          ptr_d   = (arb_idx == IW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
        end
      end

      BUSY: begin
        if (accept) begin
          acc_d = acc_q ^ sel_dat;
          cnt_d = cnt_inc;
          // last wins over the length limit: a last beat at MAX_LEN is a clean end.
          if (sel_last || cnt_inc == LW'(MAX_LEN)) begin
            state_d = DONE;
            grant_d = '0;
            rv_d    = 1'b1;
            rdat_d  = acc_q ^ sel_dat;
            rid_d   = gidx_q;
            rlen_d  = cnt_inc;
            rerr_d  = !sel_last;
          end
        end else if (timeout) begin
          state_d = DONE;
          grant_d = '0;
          rv_d    = 1'b1;
          rdat_d  = acc_q;
          rid_d   = gidx_q;
          rlen_d  = cnt_q;
          rerr_d  = 1'b1;
        end
      end

      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
          rv_d    = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        rv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rdat_q  <= '0;
      rid_q   <= '0;
      rlen_q  <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rdat_q  <= rdat_d;
      rid_q   <= rid_d;
      rlen_q  <= rlen_d;
      rerr_q  <= rerr_d;
    end
  end

endmodule

// File: doc/xor_checksum_sched.md
Name: xor_checksum_sched

Overview:
- Round-robin scheduler that shares one XOR checksum accumulator between NUM_REQ requesters.
- Grants one requester per packet, folds each accepted beat into a running XOR, and presents the final checksum with requester ID and beat count on a valid/ready result port.
- Sits between packet sources and the downstream checksum consumer; it is the sequencing layer around the XOR datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, beat and checksum width
- MAX_LEN, 16, max beats per packet before forced termination
- TIMEOUT_CYC, 32, idle-beat watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester packet request, held until granted
- in_valid  in  NUM_REQ  per-requester beat valid
- in_data  in  NUM_REQ*DATA_W  flattened beats; requester i uses bits [i*DATA_W +: DATA_W]
- in_last  in  NUM_REQ  final beat of packet
- in_ready  out  NUM_REQ  beat accepted when in_valid[i] & in_ready[i]
- grant  out  NUM_REQ  one-hot current owner, 0 when idle
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  DATA_W  XOR of all accepted beats
- res_id  out  $clog2(NUM_REQ)  requester index
- res_len  out  $clog2(MAX_LEN)+1  accepted beat count
- res_err  out  1  packet truncated (MAX_LEN hit, or timeout)

Behaviour:
- Reset (async, rst=1): state IDLE; grant=0, in_ready=0, res_valid=0, res_data=0, res_id=0, res_len=0, res_err=0; accumulator=0; RR pointer=0. A partial packet is discarded with no result.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Search req starting at pointer, wrapping modulo NUM_REQ; the first set bit wins.
  - Next edge: grant=onehot(winner), state=BUSY, acc=0, count=0, pointer=winner+1 (wraps to 0).
  - No req: stay IDLE.
  - Grant latency: 1 cycle from req sample.
- BUSY:
  - in_ready[g]=1 for the granted index only, combinational from state/grant; all other in_ready=0.
  - Beat accept: acc^=data, count+=1.
  - Beat accepted with in_last=1: go to DONE; res_data=acc^data, res_len=count+1, res_id=g, res_err=0, res_valid=1, grant=0.
  - Beat accepted with count+1==MAX_LEN and no last: same transition with res_err=1. Later beats from that requester wait for a new grant.
  - Deasserting req while BUSY is ignored; the packet ends only on last, MAX_LEN or timeout.
  - in_valid from non-granted requesters is ignored.
- DONE:
  - Hold all res_* stable while res_valid=1 and res_ready=0.
  - res_valid & res_ready: next edge res_valid=0, state=IDLE. The new arbitration happens in IDLE, so minimum packet spacing is 1 idle cycle.
  - res_ready asserted in other states has no effect.
- A single-beat packet (valid & last on the first BUSY cycle) gives res_len=1 and res_data=that beat.
- All XOR and count arithmetic is unsigned, with no carries; res_len never exceeds MAX_LEN.

Optional Feature:
- Macro XOR_SCHED_TIMEOUT_EN.
- Defined: a BUSY watchdog counts consecutive cycles with no accepted beat and resets on every accept. Reaching TIMEOUT_CYC moves to DONE with res_err=1, res_data=acc, res_len=count; the count may be 0.
- Undefined: there is no watchdog and BUSY waits indefinitely. TIMEOUT_CYC is unused.

Decomposition:
- Package xor_sched_pkg holds:
  - the state enum (IDLE/BUSY/DONE)
  - the function for the ID width ($clog2(NUM_REQ))
  - the function for the length width
- Sub-module rr_arbiter: combinational round-robin pick from req and pointer, giving a one-hot winner and its index. It is reusable by other shared-resource blocks.

Test Plan:
- Reset default: rst pulse mid-BUSY (req[1] granted, 2 of 3 beats sent) -> grant=0, res_valid=0 immediately. After release the pointer=0, and req=4'b0011 grants requester 0.
- Basic checksum: requester 2 sends 8'hA5, 8'h3C, 8'h0F (last) -> res_data=8'h96, res_id=2, res_len=3, res_err=0.
- Round-robin fairness: req=4'b1111 held, single-beat packets -> grant order 0,1,2,3,0; every grant is one-hot.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_* stable and no new grant. res_ready=1 -> IDLE next edge, then the next grant after 1 cycle.
- MAX_LEN truncation: requester 3 streams 16 beats of 8'h01 without last -> res_len=16, res_data=8'h00, res_err=1; the 17th beat is held off with in_ready=0.
- Timeout (macro defined, TIMEOUT_CYC=32): grant requester 1, send 1 beat 8'h55, then stall -> 32 cycles later res_err=1, res_data=8'h55, res_len=1. With the macro undefined -> still BUSY after 100 cycles.
